mem_port_arbiter: RTL and testbench

- Shares the single byte-wide memory port between two requesters.
- Requester 0 is the multicycle CPU controller: instruction fetch, LB and SB.
- Requester 1 is the program loader/debug port.
- Requests are transaction-based with round-robin arbitration, a lock for atomic multi-byte sequences (the 4-byte instruction fetch), and a timeout on unresponsive memory.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide memory port between two requesters: port 0 (CPU
//   controller: fetch, LB, SB) and port 1 (program loader / debug port).
//   Transactions are arbitrated round-robin in IDLE. A requester holding
//   lock keeps ownership across transactions (4-byte instruction fetch).
//   An access with no mem_ack for TIMEOUT cycles is aborted with err.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req/we/lock/addr/wdata[0|1]  per-port request, direction, lock, address, data
//   gnt[0|1]                     port currently owns the memory port
//   ack[0|1], err[0|1]           one-cycle completion / timeout pulses
//   rdata                        read data of last completed transaction
//   mem_req/we/addr/wdata        registered memory-side request
//   mem_rdata, mem_ack           memory response (mem_ack is a one-cycle pulse)
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            last_owner, last_owner_nxt;
    logic            forced, forced_nxt;
    logic [TW-1:0]   cnt, cnt_nxt;
    logic            gnt0_nxt, gnt1_nxt, ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
    logic            mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt, rdata_nxt;

    logic            req_own, lock_own, win, load, lsel;

    assign req_own  = owner ? req1  : req0;
    assign lock_own = owner ? lock1 : lock0;
    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign win      = (req0 && req1) ? ~last_owner : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            forced     <= 1'b0;
            cnt        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            forced     <= forced_nxt;
            cnt        <= cnt_nxt;
            gnt0       <= gnt0_nxt;
            gnt1       <= gnt1_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            err0       <= err0_nxt;
            err1       <= err1_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            rdata      <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        forced_nxt     = forced;
        cnt_nxt        = cnt;
        gnt0_nxt       = gnt0;
        gnt1_nxt       = gnt1;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        err0_nxt       = 1'b0;
        err1_nxt       = 1'b0;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        rdata_nxt      = rdata;
        load           = 1'b0;
        lsel           = owner;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nxt  = win;
                    gnt0_nxt   = ~win;
                    gnt1_nxt   = win;
                    load       = 1'b1;
                    lsel       = win;
                    forced_nxt = 1'b0;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    rdata_nxt   = mem_rdata;
                    ack0_nxt    = ~owner;
                    ack1_nxt    = owner;
                    state_nxt   = DONE;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    // Abort: the owner loses ownership even if it holds lock.
                    mem_req_nxt = 1'b0;
                    rdata_nxt   = '0;
                    ack0_nxt    = ~owner;
                    ack1_nxt    = owner;
                    err0_nxt    = ~owner;
                    err1_nxt    = owner;
                    forced_nxt  = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            DONE: begin
                last_owner_nxt = owner;
                if (lock_own && !forced) begin
                    state_nxt = HOLD;
                end else begin
                    gnt0_nxt  = 1'b0;
                    gnt1_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                // The other port is not considered while the owner holds lock.
                if (req_own) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end else if (!lock_own) begin
                    gnt0_nxt  = 1'b0;
                    gnt1_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Request fields are captured once per transaction, at grant.
        if (load) begin
            mem_req_nxt   = 1'b1;
            cnt_nxt       = '0;
            mem_we_nxt    = lsel ? we1    : we0;
            mem_addr_nxt  = lsel ? addr1  : addr0;
            mem_wdata_nxt = lsel ? wdata1 : wdata0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, we0, lock0, gnt0, ack0, err0;
    logic       req1, we1, lock1, gnt1, ack1, err1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic [7:0] rdata;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(15), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .err1(err1),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit port; bit we; logic [7:0] addr; logic [7:0] wdata; } mexp_t;
    typedef struct { bit port; logic [7:0] rdata; bit err; } aexp_t;

    mexp_t mq[$];
    aexp_t aq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after mem_lat extra cycles, returns mem_addr ^ key.
    int         mem_lat  = 0;
    bit         mem_mute = 1'b0;
    bit         late_ack = 1'b0;
    logic [7:0] key      = 8'h00;

    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
                late_ack  = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req && !mem_mute) begin
                if (cnt == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ key;
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end else if (!mem_req) begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks each memory request start and each ack against the queues.
    initial begin
        bit    prev;
        mexp_t m;
        aexp_t a;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt0 || gnt1) chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
            if (ack0 || ack1) chk("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
            if (mem_req && !prev) begin
                if (mq.size() == 0) begin
                    chk("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    m = mq.pop_front();
                    chk("mem_gnt", {30'd0, gnt1, gnt0}, m.port ? 32'd2 : 32'd1);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_addr", {24'd0, mem_addr}, {24'd0, m.addr});
                    if (m.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.wdata});
                end
            end
            if (ack0 || ack1) begin
                if (aq.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    a = aq.pop_front();
                    chk("ack_port", {30'd0, ack1, ack0}, a.port ? 32'd2 : 32'd1);
                    chk("ack_rdata", {24'd0, rdata}, {24'd0, a.rdata});
                    chk("ack_err", {30'd0, err1, err0}, a.err ? (a.port ? 32'd2 : 32'd1) : 32'd0);
                    chk("ack_memreq_low", {31'd0, mem_req}, 32'd0);
                end
            end
            prev = mem_req;
        end
    end

    task automatic push(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rd, input bit err);
        mexp_t m;
        aexp_t a;
        m.port = port; m.we = we; m.addr = addr; m.wdata = wdata;
        a.port = port; a.rdata = rd; a.err = err;
        mq.push_back(m);
        aq.push_back(a);
    endtask

    // Waits (bounded) at negedges for an ack on the given port; counts mem_req-high cycles.
    task automatic wait_ack(input bit port, input string tag, output int hi);
        bit seen;
        seen = 1'b0;
        hi   = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) hi++;
            if (port ? ack1 : ack0) seen = 1'b1;
        end
        if (!seen) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        bit seen;
        rst_n = 1'b0;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 0);       chk("rst_gnt1", {31'd0, gnt1}, 0);
        chk("rst_ack0", {31'd0, ack0}, 0);       chk("rst_ack1", {31'd0, ack1}, 0);
        chk("rst_err0", {31'd0, err0}, 0);       chk("rst_err1", {31'd0, err1}, 0);
        chk("rst_mem_req", {31'd0, mem_req}, 0); chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);
        rst_n = 1'b1;

        // Single port 0 read, two wait cycles: 10 ^ B5 = A5.
        @(negedge clk);
        mem_lat = 2; key = 8'hB5;
        req0 = 1; addr0 = 8'h10;
        push(0, 0, 8'h10, 8'h00, 8'hA5, 0);
        wait_ack(0, "rd0", hi);
        chk("rd0_memreq_cycles", hi, 3);
        req0 = 0;
        @(negedge clk);
        chk("rd0_ack_one_cycle", {31'd0, ack0}, 0);

        // Collisions after reset: port 0 first both times.
        do_reset();
        @(negedge clk);
        mem_lat = 0; key = 8'hFF;
        req0 = 1; addr0 = 8'h20; req1 = 1; addr1 = 8'h30;
        push(0, 0, 8'h20, 8'h00, 8'hDF, 0);
        push(1, 0, 8'h30, 8'h00, 8'hCF, 0);
        wait_ack(0, "col0a", hi); req0 = 0;
        wait_ack(1, "col1a", hi); req1 = 0;
        @(negedge clk);
        req0 = 1; addr0 = 8'h21; req1 = 1; addr1 = 8'h31;
        push(0, 0, 8'h21, 8'h00, 8'hDE, 0);
        push(1, 0, 8'h31, 8'h00, 8'hCE, 0);
        wait_ack(0, "col0b", hi); req0 = 0;
        wait_ack(1, "col1b", hi); req1 = 0;

        // Locked 4-byte fetch with port 1 waiting throughout.
        @(negedge clk);
        mem_lat = 1; key = 8'h80;
        req0 = 1; lock0 = 1; addr0 = 8'h00;
        req1 = 1; addr1 = 8'h40;
        for (int i = 0; i < 4; i++) push(0, 0, 8'(i), 8'h00, 8'(8'h80 + i), 0);
        push(1, 0, 8'h40, 8'h00, 8'hC0, 0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, "fetch", hi);
            chk("fetch_gnt1_blocked", {31'd0, gnt1}, 0);
            if (i < 3) addr0 = 8'(i + 1);
            else begin req0 = 0; lock0 = 0; end
        end
        wait_ack(1, "after_fetch", hi);
        req1 = 0;

        // Timeout on a locked port 0 read; pending port 1 write served next.
        @(negedge clk);
        mem_mute = 1;
        req0 = 1; lock0 = 1; addr0 = 8'h55;
        req1 = 1; we1 = 1; addr1 = 8'h3F; wdata1 = 8'h5C;
        push(0, 0, 8'h55, 8'h00, 8'h00, 1);
        push(1, 1, 8'h3F, 8'h5C, 8'h77, 0);
        wait_ack(0, "tmo", hi);
        chk("tmo_memreq_cycles", hi, 15);
        req0 = 0;
        mem_mute = 0; mem_lat = 0; key = 8'h48;
        wait_ack(1, "wr1", hi);
        req1 = 0; we1 = 0; wdata1 = 0; lock0 = 0;

        // Asynchronous reset in the middle of ACCESS.
        @(negedge clk);
        mem_mute = 1;
        req0 = 1; addr0 = 8'h66;
        mq.push_back('{port: 1'b0, we: 1'b0, addr: 8'h66, wdata: 8'h00});
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        chk("arst_access_reached", {31'd0, seen}, 1);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 0);
        chk("arst_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("arst_rdata", {24'd0, rdata}, 0);
        @(negedge clk);
        req0 = 0; mem_mute = 0;
        @(negedge clk);
        rst_n = 1'b1;
        late_ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_ack_ignored", {30'd0, ack1, ack0}, 0);
        end
        key = 8'h00; mem_lat = 0;
        req0 = 1; addr0 = 8'h12;
        push(0, 0, 8'h12, 8'h00, 8'h12, 0);
        wait_ack(0, "post_rst", hi);
        req0 = 0;

        repeat (4) @(negedge clk);
        chk("mem_queue_drained", mq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
